// File: rtl/rv32i_types.sv
// Shared types for the cache/pmem path; the cacheline adaptor optionally builds
// per-direction line counters when CACHELINE_ADAPTOR_PERF_EN is defined.
package rv32i_types;

  localparam int unsigned LINE_WIDTH     = 256;
  localparam int unsigned BEAT_WIDTH     = 64;
  localparam int unsigned ADDR_WIDTH     = 32;
  localparam int unsigned PMEM_BURST_LEN = 4;
  localparam int unsigned BEATS          = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned CNT_WIDTH      = $clog2(BEATS);
  localparam int unsigned LINE_BYTES     = LINE_WIDTH / 8;
  localparam int unsigned PERF_WIDTH     = 32;

  typedef logic [LINE_WIDTH-1:0]                 cacheline_t;
  typedef logic [BEAT_WIDTH-1:0]                 pmem_beat_t;
  typedef logic [BEATS-1:0][BEAT_WIDTH-1:0]      line_beats_t;
  typedef logic [CNT_WIDTH-1:0]                  beat_cnt_t;
  typedef logic [ADDR_WIDTH-1:0]                 addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } adaptor_state_e;

  // Clear the byte-offset bits so the burst starts on a line boundary.
  function automatic addr_t line_align(input addr_t a);
    addr_t mask;
    mask = ~ADDR_WIDTH'(LINE_BYTES - 1);
    return a & mask;
  endfunction

endpackage

// File: rtl/cacheline_beat_buffer.sv
// Line register viewed as beats, with the beat counter that indexes it.
module cacheline_beat_buffer
  import rv32i_types::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  load_i,
  input  logic [LINE_WIDTH-1:0] line_i,
  input  logic                  beat_we_i,
  input  logic                  adv_i,
  input  logic [BEAT_WIDTH-1:0] beat_i,
  output logic [LINE_WIDTH-1:0] line_o,
  output logic [BEAT_WIDTH-1:0] wdata_o,
  output logic                  last_c
);

  line_beats_t buf_q, buf_d;
  beat_cnt_t   cnt_q, cnt_d;
  pmem_beat_t  wdata_q, wdata_d;

  // Next buffer/counter: whole-line load, single-beat store, counter advance.
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (load_i) begin
      buf_d = line_beats_t'(line_i);
    end else if (beat_we_i) begin
      buf_d[cnt_q] = beat_i;
    end
    if (start_i) begin
      cnt_d = '0;
    end else if (adv_i) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
    wdata_d = buf_d[cnt_d];
  end

  // Buffer, counter and the registered outgoing write beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
    end
  end

  assign line_o  = cacheline_t'(buf_q);
  assign wdata_o = wdata_q;
  assign last_c  = (cnt_q == CNT_WIDTH'(BEATS - 1));

endmodule

// File: rtl/cacheline_adaptor.sv
// Converts a cacheline read/write into a beat burst on pmem.
// Optional: CACHELINE_ADAPTOR_PERF_EN adds rd_line_count / wr_line_count.
module cacheline_adaptor
  import rv32i_types::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  line_read,
  input  logic                  line_write,
  input  logic [ADDR_WIDTH-1:0] line_address,
  input  logic [LINE_WIDTH-1:0] line_i,
  output logic [LINE_WIDTH-1:0] line_o,
  output logic                  line_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [BEAT_WIDTH-1:0] pmem_wdata,
  input  logic [BEAT_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
`ifdef CACHELINE_ADAPTOR_PERF_EN
  ,
  output logic [PERF_WIDTH-1:0] rd_line_count,
  output logic [PERF_WIDTH-1:0] wr_line_count
`endif
);

  adaptor_state_e state_q, state_d;
  addr_t          addr_q, addr_d;
  logic           pmem_read_q, pmem_write_q, line_resp_q;
  logic           start_c, load_c, beat_we_c, adv_c, last_c;

  cacheline_beat_buffer u_buf (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_c),
    .load_i    (load_c),
    .line_i    (line_i),
    .beat_we_i (beat_we_c),
    .adv_i     (adv_c),
    .beat_i    (pmem_rdata),
    .line_o    (line_o),
    .wdata_o   (pmem_wdata),
    .last_c    (last_c)
  );

  // Next-state and buffer control; write wins over read in IDLE.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    start_c   = 1'b0;
    load_c    = 1'b0;
    beat_we_c = 1'b0;
    adv_c     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (line_write) begin
          addr_d  = line_align(line_address);
          start_c = 1'b1;
          load_c  = 1'b1;
          state_d = WR;
        end else if (line_read) begin
          addr_d  = line_align(line_address);
          start_c = 1'b1;
          state_d = RD;
        end
      end
      RD: begin
        if (pmem_resp) begin
          beat_we_c = 1'b1;
          adv_c     = 1'b1;
          if (last_c) state_d = DONE;
        end
      end
      WR: begin
        if (pmem_resp) begin
          adv_c = 1'b1;
          if (last_c) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, address and outputs registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      line_resp_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      pmem_read_q  <= (state_d == RD);
      pmem_write_q <= (state_d == WR);
      line_resp_q  <= (state_d == DONE);
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign line_resp    = line_resp_q;
  assign pmem_address = addr_q;

`ifdef CACHELINE_ADAPTOR_PERF_EN
  logic                  is_wr_q;
  logic [PERF_WIDTH-1:0] rd_cnt_q, wr_cnt_q;

  // Remember the request type and count completed lines per direction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_wr_q  <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (start_c) is_wr_q <= load_c;
      if (state_q == DONE) begin
        if (is_wr_q) wr_cnt_q <= wr_cnt_q + PERF_WIDTH'(1);
        else         rd_cnt_q <= rd_cnt_q + PERF_WIDTH'(1);
      end
    end
  end

  assign rd_line_count = rd_cnt_q;
  assign wr_line_count = wr_cnt_q;
`endif

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Sits between the cache side of the CPU and physical memory (pmem).
- Converts one 256-bit cacheline read or write into a 4-beat, 64-bit burst on the pmem interface.
- Read bursts are reassembled into a full line; write lines are serialized beat-by-beat.
- One request is in flight at a time; the upstream cache holds its request until line_resp.

Parameters:
- LINE_WIDTH, 256, cacheline width in bits.
- BEAT_WIDTH, 64, pmem data width in bits; BEATS = LINE_WIDTH/BEAT_WIDTH (must be an integer ≥2).
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- line_read  in  1  cache requests a line fill.
- line_write  in  1  cache requests a line writeback.
- line_address  in  ADDR_WIDTH  byte address of the line.
- line_i  in  LINE_WIDTH  writeback data.
- line_o  out  LINE_WIDTH  fill data; valid when line_resp=1.
- line_resp  out  1  one-cycle completion pulse.
- pmem_read  out  1  burst read request.
- pmem_write  out  1  burst write request.
- pmem_address  out  ADDR_WIDTH  line-aligned burst address.
- pmem_wdata  out  BEAT_WIDTH  current write beat.
- pmem_rdata  in  BEAT_WIDTH  current read beat.
- pmem_resp  in  1  one beat transferred this cycle.

Behaviour:
- Reset values (async, rst=0): state=IDLE, beat counter=0, line buffer=0, address register=0. All outputs are 0: line_resp, pmem_read, pmem_write, pmem_address, pmem_wdata, line_o.
- A reset asserted mid-burst aborts the burst immediately and returns to IDLE. No line_resp is issued for the aborted request.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - If line_write=1: capture line_i and line_address with bits [log2(LINE_WIDTH/8)-1:0] forced to 0; counter=0; go to WR.
  - Else if line_read=1: capture the aligned address; counter=0; go to RD.
  - Write has priority when both are asserted.
- RD:
  - pmem_read=1 and pmem_address=captured address, held stable for the whole burst.
  - Each cycle with pmem_resp=1 stores pmem_rdata into buffer slice [counter*BEAT_WIDTH +: BEAT_WIDTH] and increments the counter. Beat 0 is the least-significant slice.
  - Cycles with pmem_resp=0 are gaps: no state change.
  - On the beat with counter=BEATS-1, go to DONE.
- WR:
  - pmem_write=1; pmem_wdata = buffer slice [counter]; pmem_address = captured address.
  - Advance on pmem_resp=1; leave for DONE after the last beat.
- DONE:
  - For exactly one cycle: line_resp=1; line_o=buffer (meaningful after a read); pmem_read=pmem_write=0. Then go to IDLE.
  - Latency with gap-free memory: request sampled at edge 0, beats land at edges 2..5, line_resp high in the cycle after edge 5.
- Deasserting the request mid-burst has no effect; the burst completes and line_resp still pulses.
- A request still asserted in the cycle after DONE is treated as a new request.
- line_o holds the last buffer contents outside DONE; consumers use it only while line_resp=1.
- The counter is log2(BEATS) bits wide and wraps to 0 after the last beat.
- pmem_resp while in IDLE or DONE is ignored.

Optional Feature:
- Macro: CACHELINE_ADAPTOR_PERF_EN.
- Defined: adds two outputs, rd_line_count and wr_line_count, each 32 bits.
  - Each increments in the DONE cycle of the matching request type.
  - Both wrap at 2^32 and reset to 0.
- Undefined: these ports and their logic do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package rv32i_types gains:
  - the cacheline_t typedef (LINE_WIDTH bits);
  - the pmem_beat_t typedef (BEAT_WIDTH bits);
  - the constant PMEM_BURST_LEN=4;
  - the adaptor state enum (IDLE, RD, WR, DONE).
- One natural sub-module, cacheline_beat_buffer: the line register with beat-indexed write and read slices plus the counter. The FSM stays in cacheline_adaptor.

Test Plan:
- Read, no gaps: line_read, address 0x0000_1234; pmem returns 0x11..11, 0x22..22, 0x33..33, 0x44..44. Required: pmem_address=0x0000_1220 throughout; line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}; line_resp high for 1 cycle, 6 cycles after the request.
- Write: line_write, address 0x0000_8000, line_i = {0xD..D, 0xC..C, 0xB..B, 0xA..A}. Required: pmem_wdata sequence A, B, C, D on the 4 resp beats; pmem_write drops in the line_resp cycle.
- Gapped read: pmem_resp pattern 1,0,0,1,1,0,1. Required: line_o correct; line_resp exactly one cycle after the fourth resp.
- Simultaneous line_read=line_write=1 at address 0x40. Required: write burst performed; no pmem_read asserted.
- Reset mid-burst: rst=0 after beat 2 of a read. Required: all outputs 0 immediately; no line_resp; a subsequent read to 0x80 completes normally.
- CACHELINE_ADAPTOR_PERF_EN defined, 3 reads then 2 writes. Required: rd_line_count=3, wr_line_count=2.
